// File: rtl/bcd_counter_n.sv
// Multi-decade BCD up/down counter with clear, validated load, and wrap/saturate boundary.
// Each decade is a small stepping cell; a combinational carry/borrow chain links the cells.

module bcd_digit (
   input  logic       up,
   input  logic       step,
   input  logic [3:0] d,
   output logic [3:0] nxt,
   output logic       carry
);
   logic at_edge;

   // A decade passes the step on when it sits at its turnover value.
   assign at_edge = up ? (d == 4'd9) : (d == 4'd0);
   assign carry   = step & at_edge;

   always_comb begin
      nxt = d;
      if (step) begin
         if (up) nxt = at_edge ? 4'd0 : d + 4'd1;
         else    nxt = at_edge ? 4'd9 : d - 4'd1;
      end
   end
endmodule

module bcd_counter_n #(
   parameter int DIGITS   = 4,
   parameter int SATURATE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  dir,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap,
   output logic                  load_err,
   output logic                  at_min,
   output logic                  at_max
);
   localparam int W = 4 * DIGITS;

   logic [DIGITS:0]   chain;
   logic [W-1:0]      stepped;
   logic [DIGITS-1:0] digit_ok;
   logic [DIGITS-1:0] digit_nine;
   logic              boundary;
   logic              load_ok;
   logic [W-1:0]      bcd_nxt;
   logic              wrap_nxt;
   logic              err_nxt;

   assign chain[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_dig
         bcd_digit u_dig (
            .up    (dir),
            .step  (chain[i]),
            .d     (bcd[4*i +: 4]),
            .nxt   (stepped[4*i +: 4]),
            .carry (chain[i+1])
         );
         assign digit_ok[i]   = (load_val[4*i +: 4] <= 4'd9);
         assign digit_nine[i] = (bcd[4*i +: 4] == 4'd9);
      end
   endgenerate

   // Carry out of the top decade means the whole count sat at its boundary.
   assign boundary = chain[DIGITS];
   assign load_ok  = &digit_ok;
   assign at_min   = (bcd == '0);
   assign at_max   = &digit_nine;

   always_comb begin
      bcd_nxt  = bcd;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (clr) begin
         bcd_nxt = '0;
      end else if (load) begin
         if (load_ok) bcd_nxt = load_val;
         else         err_nxt = 1'b1;
      end else if (en) begin
         wrap_nxt = boundary;
         // Wrapping falls out of the chain naturally; saturation just refuses the step.
         if (!((SATURATE != 0) && boundary)) bcd_nxt = stepped;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd      <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         bcd      <= bcd_nxt;
         wrap     <= wrap_nxt;
         load_err <= err_nxt;
      end
   end
endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD up/down counter that generalises the single-digit BCD counter to DIGITS cascaded decades. It adds count enable, synchronous clear, validated parallel load, and a selectable wrap/saturate boundary mode. It reports boundary events through registered pulses. It drives the seven-segment display path directly and also serves as a general event/timer counter in lab designs.

## Interface
Parameters:
- DIGITS, 4: number of BCD decades, legal range 1..8.
- SATURATE, 0: boundary mode. 0 wraps around; 1 holds at the boundary.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i], with digit 0 least significant.
- en  input  1  count enable; one step per cycle while high.
- dir  input  1  direction; 1 counts up, 0 counts down.
- bcd  output  4*DIGITS  current count, registered, same digit packing as load_val.
- wrap  output  1  registered one-cycle pulse on a boundary event: a wrap (SATURATE=0) or a blocked step (SATURATE=1).
- load_err  output  1  registered one-cycle pulse when a load is rejected.
- at_min  output  1  combinational; high when bcd is all zeros.
- at_max  output  1  combinational; high when every digit equals 9.

## Operation
- Reset (rst_n low, asynchronous): bcd=0, wrap=0, load_err=0. With the default DIGITS=4, at_min=1 and at_max=0 during reset.
- Per-cycle priority is clr > load > en. An operation of lower priority in the same cycle is ignored.
- clr: bcd<=0. wrap and load_err are 0 that cycle.
- load, all digits of load_val in 0..9: bcd<=load_val, load_err=0.
- load, any digit of load_val >9: bcd holds, load_err pulses 1. The count does not step that cycle, even if en is high.
- en with dir=1: digit 0 increments. Digit i increments only if digits 0..i-1 are all 9. A digit that reaches 9 and steps goes to 0 (decimal carry ripple within one cycle).
- en with dir=0: digit 0 decrements. Digit i decrements only if digits 0..i-1 are all 0. A digit at 0 that steps goes to 9 (borrow ripple).
- Boundary, SATURATE=0:
  - Up from all-9s gives all-0s.
  - Down from all-0s gives all-9s.
  - wrap pulses on either event.
- Boundary, SATURATE=1:
  - Up at all-9s holds at all-9s.
  - Down at all-0s holds at all-0s.
  - wrap pulses on every such blocked step, and repeats each cycle that en stays high.
- en low, no clr, no load: bcd holds; wrap=0 and load_err=0.
- Digit arithmetic is 4-bit per decade. Internal state never holds a non-BCD digit, because load validation guarantees it.
- DIGITS=1 must behave identically to the single-digit BCD counter when clr=0, load=0 and en=1.

## Timing
- Latency from input to output is one cycle. Inputs are sampled at rising edge N; bcd, wrap and load_err reflect them after edge N.
- wrap and load_err are high for exactly one cycle per causing edge. They are deasserted at the next edge unless the cause repeats.
- at_min and at_max are pure decodes of the registered bcd, with no extra latency.
- Reset asserted mid-count forces all registered outputs to reset values immediately, with no clock needed. Counting resumes on the first rising edge after rst_n deasserts.
- dir may change on any cycle and takes effect on the step at that edge. There is no direction-change penalty.
- The full carry/borrow chain is combinational within one cycle. The design is timed at the lab clock for DIGITS=8.

## Test plan
- Reset behaviour (DIGITS=4): assert rst_n low mid-count from 0x0457 -> bcd=0x0000, at_min=1, wrap=0, with no clock edge needed.
- Up-count ripple (DIGITS=4, SATURATE=0): from 0x0999 with en=1, dir=1 -> next 0x1000, wrap=0.
  - From 0x9999 -> next 0x0000 with wrap=1 for one cycle.
- Down-count ripple (DIGITS=4, SATURATE=0): from 0x1000 with dir=0 -> next 0x0999.
  - From 0x0000 -> next 0x9999, wrap=1, at_max=1.
- Saturate mode (DIGITS=4, SATURATE=1): at 0x9999, hold en=1, dir=1 for 3 cycles -> bcd stays 0x9999, wrap=1 on all 3 cycles.
  - Then dir=0 -> 0x9998, wrap=0.
- Load validation (DIGITS=4): load_val=0x1234 -> bcd=0x1234.
  - load_val=0x12A4 with en=1 -> bcd holds 0x1234, load_err=1 for one cycle, no step taken.
- Priority: clr=1, load=1 and en=1 in the same cycle from 0x5555 -> bcd=0x0000.
  - Then load=1 and en=1 with load_val=0x0042 -> bcd=0x0042, not 0x0043.
